// File: rtl/fifo_traffic_gen.sv
// fifo_traffic_gen: constrained FIFO stimulus source and end-to-end checker for one tracked element.
// Ports: clk, rst (async active-low); en, push_force, pop_force steer traffic; full, empty,
// data_out come from the FIFO; push, pop, data_in drive it; start pulses on the tracked push,
// tracked_data holds its value, occ is the modelled occupancy, done/err are sticky results.
module fifo_traffic_gen #(
  parameter int          WIDTH       = 8,
  parameter int          DEPTH       = 8,
  parameter int          WARMUP      = 4,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter logic [7:0]  PUSH_THRESH = 8'd128,
  parameter logic [7:0]  POP_THRESH  = 8'd96
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       push_force,
  input  logic                       pop_force,
  input  logic                       full,
  input  logic                       empty,
  input  logic [WIDTH-1:0]           data_out,
  output logic                       push,
  output logic                       pop,
  output logic [WIDTH-1:0]           data_in,
  output logic                       start,
  output logic [WIDTH-1:0]           tracked_data,
  output logic [$clog2(DEPTH+1)-1:0] occ,
  output logic                       done,
  output logic [1:0]                 err
);
  localparam int OW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(WARMUP + 2);
  typedef enum logic [1:0] {IDLE, WARM, TRACK, DONE} state_t;
  state_t           state;
  logic [15:0]      lfsr;
  logic [WIDTH-1:0] seq;
  logic [OW-1:0]    ahead;
  logic [CW-1:0]    warm;
  logic             pre;
  // Gating with rst keeps push/pop low for the whole time reset is held.
  assign push    = rst & en & (push_force | (lfsr[7:0] < PUSH_THRESH)) & ~full;
  assign pop     = rst & en & (pop_force | (lfsr[15:8] < POP_THRESH)) & ~empty;
  assign data_in = seq;
  // Pushes made while still in IDLE count toward warm-up, so the tracked push is
  // always the (WARMUP+1)th push since reset.
  assign pre     = (state == IDLE) | (state == WARM);
  assign start   = pre & push & (warm == CW'(WARMUP));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr         <= SEED;
      seq          <= '0;
      occ          <= '0;
      ahead        <= '0;
      warm         <= '0;
      tracked_data <= '0;
      state        <= IDLE;
      done         <= 1'b0;
      err          <= 2'b00;
    end else begin
      if (en) lfsr <= lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
      if (push) seq <= seq + 1'b1;
      occ <= occ + OW'(push) - OW'(pop);
      if ((full != (occ == OW'(DEPTH))) | (empty != (occ == '0))) err[1] <= 1'b1;
      if (start) begin
        state        <= TRACK;
        tracked_data <= data_in;
        ahead        <= occ - OW'(pop);
      end else begin
        if (pre & push) warm <= warm + 1'b1;
        if ((state == IDLE) & en) state <= WARM;
      end
      if ((state == TRACK) & pop) begin
        if (ahead != '0) ahead <= ahead - 1'b1;
        else begin
          if (data_out == tracked_data) done <= 1'b1;
          else err[0] <= 1'b1;
          state <= DONE;
        end
      end
    end
  end
endmodule

// File: tb/tb_fifo_traffic_gen.sv
// tb_fifo_traffic_gen: scoreboard bench driving fifo_traffic_gen against an ideal FWFT FIFO model.
module tb_fifo_traffic_gen;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0, push_force = 1'b0, pop_force = 1'b0;
  logic full, empty, push, pop, start, done;
  logic [7:0] data_out, data_in, tracked_data;
  logic [3:0] occ;
  logic [1:0] err;
  logic [7:0] mem [8];
  logic [2:0] rd = 3'd0, wr = 3'd0;
  logic [3:0] cnt = 4'd0;
  int npop = 0;
  logic force_full = 1'b0, corrupt = 1'b0;
  logic [15:0] ml;
  logic [7:0] m_seq, m_trk;
  int m_npush;
  logic m_started, m_fin, m_done;
  logic [1:0] m_err;
  logic [8:0] sb [$];
  logic [25:0] s_obs, s_exp;
  logic s_push, s_start;
  int checks = 0, fails = 0;

  assign full     = force_full | (cnt == 4'd8);
  assign empty    = (cnt == 4'd0);
  assign data_out = (corrupt && npop == 4) ? 8'hFF : mem[rd];

  fifo_traffic_gen dut (
    .clk(clk), .rst(rst), .en(en), .push_force(push_force), .pop_force(pop_force),
    .full(full), .empty(empty), .data_out(data_out), .push(push), .pop(pop),
    .data_in(data_in), .start(start), .tracked_data(tracked_data), .occ(occ),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    ml = 16'hACE1; m_seq = 8'd0; m_trk = 8'd0; m_npush = 0;
    m_started = 1'b0; m_fin = 1'b0; m_done = 1'b0; m_err = 2'b00;
    sb.delete();
    rd = 3'd0; wr = 3'd0; cnt = 4'd0; npop = 0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b0; push_force = 1'b0; pop_force = 1'b0;
    force_full = 1'b0; corrupt = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // Samples the DUT at the falling edge, builds the expectation, then advances the
  // reference model and the FIFO model just after the rising edge.
  task automatic tick();
    logic e_push, e_pop, e_start, fl, em, p, q;
    logic [7:0] d, din;
    logic [8:0] ent;
    @(negedge clk);
    e_push  = rst && en && (push_force || ml[7:0] < 8'd128) && !full;
    e_pop   = rst && en && (pop_force || ml[15:8] < 8'd96) && !empty;
    e_start = e_push && !m_started && m_npush == 4;
    s_exp = {e_push, e_pop, e_start, 4'(sb.size()), e_push ? m_seq : 8'h00, m_done, m_err, m_trk};
    s_obs = {push, pop, start, occ, push ? data_in : 8'h00, done, err, tracked_data};
    s_push = push; s_start = start;
    p = push; q = pop; fl = full; em = empty; d = data_out; din = data_in;
    @(posedge clk); #1;
    if (en) ml = {1'b0, ml[15:1]} ^ (ml[0] ? 16'hB400 : 16'h0000);
    if ((fl != (sb.size() == 8)) || (em != (sb.size() == 0))) m_err[1] = 1'b1;
    if (e_pop) begin
      ent = sb.pop_front();
      if (ent[8] && !m_fin) begin
        if (d == m_trk) m_done = 1'b1;
        else m_err[0] = 1'b1;
        m_fin = 1'b1;
      end
    end
    if (e_push) begin
      sb.push_back({e_start, m_seq});
      if (e_start) begin m_trk = m_seq; m_started = 1'b1; end
      m_seq = m_seq + 8'd1;
      m_npush++;
    end
    if (q) begin rd = rd + 3'd1; cnt = cnt - 4'd1; npop++; end
    if (p) begin mem[wr] = din; wr = wr + 3'd1; cnt = cnt + 4'd1; end
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; push_force = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({push, pop, start, done} !== 4'b0000) begin fails++; $display("FAIL reset_ctl: got %b want 0000", {push, pop, start, done}); end
    checks++;
    if (err !== 2'b00) begin fails++; $display("FAIL reset_err: got %b want 00", err); end
    checks++;
    if (occ !== 4'd0) begin fails++; $display("FAIL reset_occ: got %0d want 0", occ); end
    checks++;
    if ({tracked_data, data_in} !== 16'h0000) begin fails++; $display("FAIL reset_data: got %h want 0000", {tracked_data, data_in}); end
    @(posedge clk); #1;
    rst = 1'b1; en = 1'b0; push_force = 1'b0;
  endtask

  task automatic test_fill_drain();
    en = 1'b1; push_force = 1'b1; pop_force = 1'b0;
    for (int i = 0; i < 48; i++) begin
      if (i == 24) begin push_force = 1'b0; pop_force = 1'b1; end
      tick();
      checks++;
      if (s_obs !== s_exp) begin fails++; $display("FAIL fill_drain cycle %0d: got %h want %h", i, s_obs, s_exp); end
    end
    checks++;
    if ({done, err, tracked_data} !== {1'b1, 2'b00, 8'd4}) begin
      fails++; $display("FAIL fill_drain_end: got done=%b err=%b trk=%h want 1 00 04", done, err, tracked_data);
    end
  endtask

  task automatic test_corrupt();
    do_reset();
    corrupt = 1'b1; en = 1'b1; push_force = 1'b1;
    for (int i = 0; i < 48; i++) begin
      if (i == 24) begin push_force = 1'b0; pop_force = 1'b1; end
      tick();
      checks++;
      if (s_obs !== s_exp) begin fails++; $display("FAIL corrupt cycle %0d: got %h want %h", i, s_obs, s_exp); end
    end
    checks++;
    if ({done, err[0]} !== 2'b01) begin fails++; $display("FAIL corrupt_end: got done=%b err0=%b want 0 1", done, err[0]); end
    corrupt = 1'b0;
  endtask

  task automatic test_flag_fault();
    do_reset();
    en = 1'b1; push_force = 1'b1;
    for (int i = 0; i < 16 && sb.size() != 3; i++) begin
      tick();
      checks++;
      if (s_obs !== s_exp) begin fails++; $display("FAIL flag_setup cycle %0d: got %h want %h", i, s_obs, s_exp); end
    end
    push_force = 1'b0;
    checks++;
    if (err !== 2'b00) begin fails++; $display("FAIL flag_pre: got err=%b want 00", err); end
    force_full = 1'b1;
    tick();
    checks++;
    if (s_obs !== s_exp) begin fails++; $display("FAIL flag_cycle: got %h want %h", s_obs, s_exp); end
    checks++;
    if (s_push !== 1'b0) begin fails++; $display("FAIL flag_push: got %b want 0", s_push); end
    checks++;
    if (err[1] !== 1'b1) begin fails++; $display("FAIL flag_err: got %b want 1", err[1]); end
    force_full = 1'b0;
  endtask

  task automatic test_concurrent();
    int p;
    do_reset();
    en = 1'b1; push_force = 1'b1;
    for (int i = 0; i < 12 && !m_started; i++) begin
      tick();
      checks++;
      if (s_obs !== s_exp) begin fails++; $display("FAIL conc_setup cycle %0d: got %h want %h", i, s_obs, s_exp); end
    end
    pop_force = 1'b1;
    for (int i = 0; i < 16 && !m_fin; i++) begin
      p = sb.size();
      tick();
      checks++;
      if (s_obs !== s_exp) begin fails++; $display("FAIL conc cycle %0d: got %h want %h", i, s_obs, s_exp); end
      if (s_obs[25] && s_obs[24]) begin
        checks++;
        if (occ !== 4'(p)) begin fails++; $display("FAIL conc_occ cycle %0d: got %0d want %0d", i, occ, p); end
      end
    end
    checks++;
    if ({done, err} !== 3'b100) begin fails++; $display("FAIL conc_end: got done=%b err=%b want 1 00", done, err); end
  endtask

  task automatic test_mid_reset();
    logic got;
    do_reset();
    en = 1'b1; push_force = 1'b1;
    for (int i = 0; i < 16 && !(m_started && sb.size() >= 6); i++) begin
      tick();
      checks++;
      if (s_obs !== s_exp) begin fails++; $display("FAIL mid_setup cycle %0d: got %h want %h", i, s_obs, s_exp); end
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({push, pop, start, done, err, occ, tracked_data, data_in} !== 26'd0) begin
      fails++; $display("FAIL mid_reset_outputs: got %h want 0", {push, pop, start, done, err, occ, tracked_data, data_in});
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      tick();
      checks++;
      if (s_obs !== s_exp) begin fails++; $display("FAIL mid_restart cycle %0d: got %h want %h", i, s_obs, s_exp); end
      got = s_start;
    end
    checks++;
    if (!got || tracked_data !== 8'd4) begin fails++; $display("FAIL mid_restart_track: got start=%b trk=%h want 1 04", got, tracked_data); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_corrupt();
    test_flag_fault();
    test_concurrent();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
